// File: rtl/wvb_rd_arbiter_if.sv
// Bus between the waveform-buffer channels, the round-robin read arbiter and the readout engine.
// The arbiter takes the master modport; the channel/engine side takes the slave modport.
interface wvb_rd_arbiter_if #(
  parameter int unsigned P_N_CHAN = 8,
  parameter int unsigned P_CHAN_W = 3
);
  logic [P_N_CHAN-1:0] chan_en;
  logic [P_N_CHAN-1:0] hdr_empty;
  logic [P_N_CHAN-1:0] wvb_rddone;
  logic                rd_req;
  logic [P_CHAN_W-1:0] rd_chan;
  logic                rd_ack;
  logic                rd_done;

  modport master (
    input  chan_en,
    input  hdr_empty,
    input  rd_ack,
    input  rd_done,
    output wvb_rddone,
    output rd_req,
    output rd_chan
  );

  modport slave (
    output chan_en,
    output hdr_empty,
    output rd_ack,
    output rd_done,
    input  wvb_rddone,
    input  rd_req,
    input  rd_chan
  );
endinterface

// File: rtl/wvb_rd_arbiter.sv
// Round-robin readout scheduler for the per-channel waveform buffers.
// Optional readout timeout enabled by defining WVB_RD_ARB_TIMEOUT_EN.
module wvb_rd_arbiter #(
  parameter int unsigned P_N_CHAN  = 8,
  parameter int unsigned P_CHAN_W  = 3,
  parameter int unsigned P_TIMEOUT = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  wvb_rd_arbiter_if.master        bus,
  output logic                    busy,
  output logic [15:0]             n_served,
  output logic                    timeout_err
);

  typedef enum logic [2:0] {StIdle, StGrant, StWaitDone, StRelease, StHoldoff} state_e;

  state_e              state_q, state_d;
  logic [P_CHAN_W-1:0] last_grant_q, last_grant_d;
  logic [P_CHAN_W-1:0] rd_chan_q, rd_chan_d;
  logic [15:0]         n_served_q, n_served_d;
  logic [P_N_CHAN-1:0] elig, elig_sh;
  logic [P_CHAN_W-1:0] win_idx;
  logic                win_found;
  logic                tmo_hit;

  assign elig = bus.chan_en & ~bus.hdr_empty;

  // First eligible channel at or after last_grant+1, wrapping modulo P_N_CHAN.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    elig_sh   = '0;
    for (int unsigned i = 1; i <= P_N_CHAN; i++) begin
      elig_sh = elig >> ((32'(last_grant_q) + i) % P_N_CHAN);
      if (!win_found && elig_sh[0]) begin
        win_found = 1'b1;
        win_idx   = P_CHAN_W'((32'(last_grant_q) + i) % P_N_CHAN);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rd_chan_d    = rd_chan_q;
    n_served_d   = n_served_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          rd_chan_d = win_idx;
          state_d   = StGrant;
        end
      end
      StGrant: begin
        if (bus.rd_ack) begin
          state_d = bus.rd_done ? StRelease : StWaitDone;
        end else if (tmo_hit) begin
          state_d = StHoldoff;
        end
      end
      StWaitDone: begin
        if (bus.rd_done) begin
          state_d = StRelease;
        end else if (tmo_hit) begin
          state_d = StHoldoff;
        end
      end
      StRelease: begin
        last_grant_d = rd_chan_q;
        if (n_served_q != 16'hFFFF) begin
          n_served_d = n_served_q + 16'd1;
        end
        state_d = StHoldoff;
      end
      StHoldoff: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= P_CHAN_W'(P_N_CHAN - 1);
      rd_chan_q    <= '0;
      n_served_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rd_chan_q    <= rd_chan_d;
      n_served_q   <= n_served_d;
    end
  end

`ifdef WVB_RD_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        timeout_err_q;
  logic        in_read;

  assign in_read = (state_q == StGrant) || (state_q == StWaitDone);
  // Fires on the P_TIMEOUT-th cycle spent in GRANT/WAIT_DONE.
  assign tmo_hit = in_read && (({1'b0, tmo_cnt_q} + 17'd1) >= 17'(P_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (in_read) begin
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
      end else begin
        tmo_cnt_q <= '0;
      end
      if (in_read && (state_d == StHoldoff)) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign bus.rd_req     = (state_q == StGrant);
  assign bus.rd_chan    = rd_chan_q;
  assign bus.wvb_rddone = (state_q == StRelease) ? (P_N_CHAN'(1) << rd_chan_q) : '0;
  assign busy           = (state_q != StIdle);
  assign n_served       = n_served_q;

endmodule

// File: tb/tb_wvb_rd_arbiter.sv
// Self-checking bench for wvb_rd_arbiter: expected wvb_rddone pulses are queued as reads are
// issued and matched against every pulse the DUT produces.
module tb_wvb_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] n_served;
  logic        timeout_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  sb_q[$];

  wvb_rd_arbiter_if #(.P_N_CHAN(8), .P_CHAN_W(3)) bus_if ();

  wvb_rd_arbiter #(
    .P_N_CHAN (8),
    .P_CHAN_W (3),
    .P_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if.master),
    .busy       (busy),
    .n_served   (n_served),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every rddone pulse must match the oldest queued expectation; extra pulses have none.
  always @(negedge clk) begin
    if (!rst && bus_if.wvb_rddone != 8'h00) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rddone", 32'(bus_if.wvb_rddone), 32'h0);
      end else begin
        chk("rddone", 32'(bus_if.wvb_rddone), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (bus_if.rd_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus_if.rd_req !== 1'b1) chk("req_timeout", 32'(bus_if.rd_req), 32'h1);
  endtask

  // Waits for a request, checks the channel, then returns ack+done together after dly cycles.
  task automatic do_read(input int dly, input int exp_chan, input logic [7:0] pop);
    logic [7:0] oh;
    wait_req();
    chk("grant_chan", 32'(bus_if.rd_chan), 32'(exp_chan));
    oh = 8'h01 << exp_chan;
    sb_q.push_back(oh);
    repeat (dly) @(negedge clk);
    bus_if.rd_ack  = 1'b1;
    bus_if.rd_done = 1'b1;
    bus_if.hdr_empty = bus_if.hdr_empty | pop;
    @(negedge clk);
    bus_if.rd_ack  = 1'b0;
    bus_if.rd_done = 1'b0;
  endtask

  initial begin
    bus_if.chan_en   = 8'hFF;
    bus_if.hdr_empty = 8'hFF;
    bus_if.rd_ack    = 1'b0;
    bus_if.rd_done   = 1'b0;
    do_reset();

    // Reset state
    chk("rst_rd_req", 32'(bus_if.rd_req), 32'h0);
    chk("rst_rd_chan", 32'(bus_if.rd_chan), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_n_served", 32'(n_served), 32'h0);
    chk("rst_timeout_err", 32'(timeout_err), 32'h0);

    // Single channel, ack+done two cycles after the request
    bus_if.hdr_empty = 8'hFE;
    @(negedge clk);
    chk("t1_req_latency", 32'(bus_if.rd_req), 32'h1);
    do_read(2, 0, 8'h01);
    chk("t1_busy_release", 32'(busy), 32'h1);
    @(negedge clk);
    chk("t1_n_served", 32'(n_served), 32'h1);
    @(negedge clk);
    chk("t1_busy_idle", 32'(busy), 32'h0);

    // All channels eligible, immediate ack+done: strict rotation
    do_reset();
    bus_if.hdr_empty = 8'h00;
    for (int i = 0; i < 9; i++) do_read(0, i % 8, 8'h00);
    repeat (3) @(negedge clk);
    bus_if.hdr_empty = 8'hFF;
    repeat (4) @(negedge clk);
    chk("t2_n_served", 32'(n_served), 32'd9);

    // Channel 5 masked off: only channel 2 ever served
    do_reset();
    bus_if.chan_en   = 8'hDF;
    bus_if.hdr_empty = 8'hDB;
    for (int i = 0; i < 3; i++) do_read(0, 2, 8'h00);
    bus_if.hdr_empty = 8'hFF;
    repeat (4) @(negedge clk);

    // Enable dropped mid-read: read completes, channel not re-granted
    do_reset();
    bus_if.chan_en   = 8'hFF;
    bus_if.hdr_empty = 8'hF7;
    wait_req();
    chk("t4_grant_chan", 32'(bus_if.rd_chan), 32'h3);
    bus_if.rd_ack = 1'b1;
    @(negedge clk);
    bus_if.rd_ack  = 1'b0;
    bus_if.chan_en = 8'hF7;
    chk("t4_req_dropped", 32'(bus_if.rd_req), 32'h0);
    repeat (10) @(negedge clk);
    sb_q.push_back(8'h08);
    bus_if.rd_done = 1'b1;
    @(negedge clk);
    bus_if.rd_done = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_no_regrant", 32'(busy), 32'h0);
    chk("t4_n_served", 32'(n_served), 32'h1);

    // n_served saturation
    do_reset();
    bus_if.chan_en   = 8'hFF;
    bus_if.hdr_empty = 8'hFE;
    force dut.n_served_q = 16'hFFFD;
    #1;
    release dut.n_served_q;
    for (int i = 0; i < 3; i++) begin
      do_read(0, 0, 8'h00);
      @(negedge clk);
      chk("t5_n_served", 32'(n_served), (i == 0) ? 32'hFFFE : 32'hFFFF);
    end
    bus_if.hdr_empty = 8'hFF;
    repeat (3) @(negedge clk);

    // Reset during WAIT_DONE, then channel 0 first
    bus_if.hdr_empty = 8'hEF;
    wait_req();
    chk("t5_grant_chan4", 32'(bus_if.rd_chan), 32'h4);
    bus_if.rd_ack = 1'b1;
    @(negedge clk);
    bus_if.rd_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_rd_req", 32'(bus_if.rd_req), 32'h0);
    chk("t5_rst_rd_chan", 32'(bus_if.rd_chan), 32'h0);
    chk("t5_rst_n_served", 32'(n_served), 32'h0);
    chk("t5_rst_rddone", 32'(bus_if.wvb_rddone), 32'h0);
    bus_if.hdr_empty = 8'hEE;
    @(negedge clk);
    rst = 1'b0;
    do_read(0, 0, 8'h01);
    repeat (2) @(negedge clk);
    chk("t5_post_rst_n_served", 32'(n_served), 32'h1);

    // rd_done withheld
    bus_if.hdr_empty = 8'hFD;
    wait_req();
    chk("t6_grant_chan", 32'(bus_if.rd_chan), 32'h1);
    bus_if.rd_ack = 1'b1;
    @(negedge clk);
    bus_if.rd_ack = 1'b0;
    repeat (30) @(negedge clk);
`ifdef WVB_RD_ARB_TIMEOUT_EN
    chk("t6_timeout_err", 32'(timeout_err), 32'h1);
    chk("t6_n_served", 32'(n_served), 32'h1);
    chk("t6_regrant_chan", 32'(bus_if.rd_chan), 32'h1);
`else
    chk("t6_still_busy", 32'(busy), 32'h1);
    chk("t6_rd_req_low", 32'(bus_if.rd_req), 32'h0);
    chk("t6_timeout_err", 32'(timeout_err), 32'h0);
    chk("t6_n_served", 32'(n_served), 32'h1);
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
